// File: rtl/dbg_pager_pkg.sv
// Shared constants and helpers for the debug-word pager: blank pattern,
// hex-to-segment encoding and page-index width.
package dbg_pager_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_FWD  = 2'd1,
    STEP_BACK = 2'd2
  } page_step_e;

  // Active-low segments in gfedcba order.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  function automatic int page_width(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/dbg_pager_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter, debounced level
// and a one-cycle pulse on each accepted 0->1 transition.
module pgr_debounce
  import dbg_pager_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 65536
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             meta_r;
  logic             sync_r;
  logic             level_r;
  logic             press_r;
  logic [CNT_W-1:0] cnt_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= raw;
      sync_r <= meta_r;
    end
  end

  // The level flips on the DEBOUNCE_CYC-th consecutive disagreeing cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r   <= CNT_ZERO;
      level_r <= 1'b0;
      press_r <= 1'b0;
    end else if (sync_r == level_r) begin
      cnt_r   <= CNT_ZERO;
      press_r <= 1'b0;
    end else if (cnt_r == CNT_MAX) begin
      cnt_r   <= CNT_ZERO;
      level_r <= sync_r;
      press_r <= sync_r;
    end else begin
      cnt_r   <= cnt_r + CNT_ONE;
      press_r <= 1'b0;
    end
  end

  assign press = press_r;

endmodule

// File: rtl/dbg_pager.sv
// Debug-word pager: selects one of NUM_WORDS live or frozen words by page and
// drives it onto active-low 7-segment digits, with optional auto-scroll.
module dbg_pager
  import dbg_pager_pkg::*;
#(
  parameter int NUM_WORDS    = 4,
  parameter int WORD_W       = 16,
  parameter int DEBOUNCE_CYC = 65536,
  parameter int SCROLL_CYC   = 8333333,
  localparam int DIGITS      = WORD_W / 4,
  localparam int PAGE_W      = page_width(NUM_WORDS)
) (
  input  logic                          pgr_clk_i,
  input  logic                          pgr_rst_i,
  input  logic [NUM_WORDS*WORD_W-1:0]   pgr_words_i,
  input  logic                          pgr_next_i,
  input  logic                          pgr_prev_i,
  input  logic                          pgr_freeze_i,
  input  logic                          pgr_auto_i,
  output logic [7*DIGITS-1:0]           pgr_seg_o,
  output logic [PAGE_W-1:0]             pgr_page_o,
  output logic                          pgr_frozen_o
);

  localparam int SCR_W = (SCROLL_CYC > 1) ? $clog2(SCROLL_CYC) : 1;
  localparam logic [SCR_W-1:0]  SCR_MAX   = SCR_W'(SCROLL_CYC - 1);
  localparam logic [SCR_W-1:0]  SCR_ZERO  = SCR_W'(0);
  localparam logic [SCR_W-1:0]  SCR_ONE   = SCR_W'(1);
  localparam logic [PAGE_W-1:0] PAGE_MAX  = PAGE_W'(NUM_WORDS - 1);
  localparam logic [PAGE_W-1:0] PAGE_ZERO = PAGE_W'(0);
  localparam logic [PAGE_W-1:0] PAGE_ONE  = PAGE_W'(1);

  logic                        next_press_s;
  logic                        prev_press_s;
  logic                        frz_meta_r;
  logic                        frz_sync_r;
  logic                        auto_meta_r;
  logic                        auto_sync_r;
  logic                        scroll_tick_s;
  logic                        manual_s;
  page_step_e                  page_step_s;
  logic [PAGE_W-1:0]           page_r;
  logic [SCR_W-1:0]            scroll_cnt_r;
  logic                        frozen_r;
  logic [NUM_WORDS*WORD_W-1:0] snap_r;
  logic [WORD_W-1:0]           src_word_s;
  logic [WORD_W-1:0]           disp_r;
  logic [7*DIGITS-1:0]         seg_r;

  pgr_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_next (
    .clk   (pgr_clk_i),
    .rst   (pgr_rst_i),
    .raw   (pgr_next_i),
    .press (next_press_s)
  );

  pgr_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_prev (
    .clk   (pgr_clk_i),
    .rst   (pgr_rst_i),
    .raw   (pgr_prev_i),
    .press (prev_press_s)
  );

  always_ff @(posedge pgr_clk_i or posedge pgr_rst_i) begin
    if (pgr_rst_i) begin
      frz_meta_r  <= 1'b0;
      frz_sync_r  <= 1'b0;
      auto_meta_r <= 1'b0;
      auto_sync_r <= 1'b0;
    end else begin
      frz_meta_r  <= pgr_freeze_i;
      frz_sync_r  <= frz_meta_r;
      auto_meta_r <= pgr_auto_i;
      auto_sync_r <= auto_meta_r;
    end
  end

  assign manual_s      = next_press_s | prev_press_s;
  assign scroll_tick_s = auto_sync_r & (scroll_cnt_r == SCR_MAX);

  // Manual presses take priority; a tick coinciding with one is dropped.
  always_comb begin
    page_step_s = STEP_NONE;
    if (next_press_s && prev_press_s) begin
      page_step_s = STEP_NONE;
    end else if (next_press_s) begin
      page_step_s = STEP_FWD;
    end else if (prev_press_s) begin
      page_step_s = STEP_BACK;
    end else if (scroll_tick_s) begin
      page_step_s = STEP_FWD;
    end else begin
      page_step_s = STEP_NONE;
    end
  end

  always_ff @(posedge pgr_clk_i or posedge pgr_rst_i) begin
    if (pgr_rst_i) begin
      page_r <= PAGE_ZERO;
    end else begin
      case (page_step_s)
        STEP_FWD:  page_r <= (page_r == PAGE_MAX) ? PAGE_ZERO : page_r + PAGE_ONE;
        STEP_BACK: page_r <= (page_r == PAGE_ZERO) ? PAGE_MAX : page_r - PAGE_ONE;
        STEP_NONE: page_r <= page_r;
        default:   page_r <= page_r;
      endcase
    end
  end

  always_ff @(posedge pgr_clk_i or posedge pgr_rst_i) begin
    if (pgr_rst_i) begin
      scroll_cnt_r <= SCR_ZERO;
    end else if (!auto_sync_r || manual_s || scroll_cnt_r == SCR_MAX) begin
      scroll_cnt_r <= SCR_ZERO;
    end else begin
      scroll_cnt_r <= scroll_cnt_r + SCR_ONE;
    end
  end

  // Capture happens only on entry to freeze so the snapshot stays coherent.
  always_ff @(posedge pgr_clk_i or posedge pgr_rst_i) begin
    if (pgr_rst_i) begin
      frozen_r <= 1'b0;
      snap_r   <= {(NUM_WORDS*WORD_W){1'b0}};
    end else if (frz_sync_r && !frozen_r) begin
      frozen_r <= 1'b1;
      snap_r   <= pgr_words_i;
    end else if (!frz_sync_r) begin
      frozen_r <= 1'b0;
      snap_r   <= snap_r;
    end else begin
      frozen_r <= frozen_r;
      snap_r   <= snap_r;
    end
  end

  always_comb begin
    src_word_s = {WORD_W{1'b0}};
    for (int k = 0; k < NUM_WORDS; k++) begin
      src_word_s = (page_r == PAGE_W'(k))
                 ? (frozen_r ? snap_r[k*WORD_W +: WORD_W] : pgr_words_i[k*WORD_W +: WORD_W])
                 : src_word_s;
    end
  end

  always_ff @(posedge pgr_clk_i or posedge pgr_rst_i) begin
    if (pgr_rst_i) begin
      disp_r <= {WORD_W{1'b0}};
      seg_r  <= {DIGITS{SEG_BLANK}};
    end else begin
      disp_r <= src_word_s;
      for (int d = 0; d < DIGITS; d++) begin
        seg_r[7*d +: 7] <= hex_to_seg(disp_r[4*d +: 4]);
      end
    end
  end

  assign pgr_seg_o    = seg_r;
  assign pgr_page_o   = page_r;
  assign pgr_frozen_o = frozen_r;

endmodule

// File: tb/tb_dbg_pager.sv
// Self-checking bench for dbg_pager: encoding table, directed timing
// sequences and a randomized run against a cycle-level reference model.
module tb_dbg_pager;

  localparam int NW  = 3;
  localparam int WW  = 16;
  localparam int DEB = 4;
  localparam int SCR = 10;
  localparam int DIG = 4;
  localparam int PW  = 2;

  localparam logic [27:0] SEG_BLANK28 = 28'hFFFFFFF;
  localparam logic [27:0] SEG_1234 = {7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [27:0] SEG_ABCD = {7'h08, 7'h03, 7'h46, 7'h21};
  localparam logic [27:0] SEG_0F00 = {7'h40, 7'h0E, 7'h40, 7'h40};
  localparam logic [27:0] SEG_0000 = {7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [NW*WW-1:0] WORDS_DEF = {16'h0F00, 16'hABCD, 16'h1234};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic nxt = 1'b0;
  logic prv = 1'b0;
  logic frz = 1'b0;
  logic aut = 1'b0;
  logic [NW*WW-1:0] words = WORDS_DEF;
  logic [7*DIG-1:0] seg;
  logic [PW-1:0]    page;
  logic             frozen;

  int n_vec = 0;
  int n_bad = 0;

  dbg_pager #(
    .NUM_WORDS(NW), .WORD_W(WW), .DEBOUNCE_CYC(DEB), .SCROLL_CYC(SCR)
  ) dut (
    .pgr_clk_i(clk), .pgr_rst_i(rst), .pgr_words_i(words),
    .pgr_next_i(nxt), .pgr_prev_i(prv), .pgr_freeze_i(frz), .pgr_auto_i(aut),
    .pgr_seg_o(seg), .pgr_page_o(page), .pgr_frozen_o(frozen)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit d1[4], d2[4], m_lvl[2], m_prs[2], m_frozen;
  int m_run[2], m_page, m_scnt;
  logic [WW-1:0] m_snap[NW];
  logic [WW-1:0] m_disp;
  logic [27:0]   m_seg;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] r;
    case (n)
      4'h0: r = 7'h40; 4'h1: r = 7'h79; 4'h2: r = 7'h24; 4'h3: r = 7'h30;
      4'h4: r = 7'h19; 4'h5: r = 7'h12; 4'h6: r = 7'h02; 4'h7: r = 7'h78;
      4'h8: r = 7'h00; 4'h9: r = 7'h10; 4'hA: r = 7'h08; 4'hB: r = 7'h03;
      4'hC: r = 7'h46; 4'hD: r = 7'h21; 4'hE: r = 7'h06; 4'hF: r = 7'h0E;
      default: r = 7'h7F;
    endcase
    return r;
  endfunction

  function automatic logic [27:0] seg_word(input logic [15:0] w);
    logic [27:0] r;
    for (int d = 0; d < 4; d++) r[7*d +: 7] = hex7(w[4*d +: 4]);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin d1[i] = 1'b0; d2[i] = 1'b0; end
    for (int i = 0; i < 2; i++) begin m_lvl[i] = 1'b0; m_prs[i] = 1'b0; m_run[i] = 0; end
    for (int k = 0; k < NW; k++) m_snap[k] = 16'h0000;
    m_frozen = 1'b0;
    m_page = 0;
    m_scnt = 0;
    m_disp = 16'h0000;
    m_seg = SEG_BLANK28;
  endtask

  // One rising edge of the specified behaviour, using values present at the edge.
  task automatic model_step();
    bit raw[4], syn[4], prs_old[2], tick, manual;
    if (rst) begin
      model_reset();
      return;
    end
    raw[0] = nxt; raw[1] = prv; raw[2] = frz; raw[3] = aut;
    for (int i = 0; i < 4; i++) begin
      syn[i] = d2[i]; d2[i] = d1[i]; d1[i] = raw[i];
    end
    prs_old[0] = m_prs[0];
    prs_old[1] = m_prs[1];
    for (int i = 0; i < 2; i++) begin
      m_prs[i] = 1'b0;
      if (syn[i] != m_lvl[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_lvl[i] = syn[i];
          m_run[i] = 0;
          m_prs[i] = syn[i];
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_seg  = seg_word(m_disp);
    m_disp = m_frozen ? m_snap[m_page] : words[m_page*WW +: WW];
    tick   = syn[3] && (m_scnt == SCR - 1);
    manual = prs_old[0] || prs_old[1];
    if (prs_old[0] && !prs_old[1])      m_page = (m_page + 1) % NW;
    else if (prs_old[1] && !prs_old[0]) m_page = (m_page + NW - 1) % NW;
    else if (!manual && tick)           m_page = (m_page + 1) % NW;
    if (!syn[3] || manual || tick) m_scnt = 0;
    else                           m_scnt++;
    if (syn[2] && !m_frozen) begin
      for (int k = 0; k < NW; k++) m_snap[k] = words[k*WW +: WW];
      m_frozen = 1'b1;
    end else if (!syn[2]) begin
      m_frozen = 1'b0;
    end
  endtask

  task automatic cmp_outputs(input string tag);
    n_vec++;
    if (seg !== m_seg || page !== PW'(m_page) || frozen !== m_frozen) begin
      n_bad++;
      $display("FAIL %s t=%0t seg got %h exp %h, page got %0d exp %0d, frozen got %0b exp %0b",
               tag, $time, seg, m_seg, page, m_page, frozen, m_frozen);
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got %h expected %h", name, $time, got, exp);
    end
  endtask

  task automatic tick_cycle();
    @(posedge clk);
    model_step();
    #1;
    cmp_outputs("cycle");
  endtask

  task automatic press_btn(input logic use_next, input logic use_prev);
    nxt = use_next;
    prv = use_prev;
    repeat (8) tick_cycle();
    nxt = 1'b0;
    prv = 1'b0;
    repeat (8) tick_cycle();
  endtask

  typedef struct {
    logic [15:0] w;
    logic [27:0] s;
  } vec_t;

  vec_t tbl[6];
  int   cd[4];
  int   rst_hold;
  logic v;

  initial begin
    tbl[0] = '{16'h0123, {7'h40, 7'h79, 7'h24, 7'h30}};
    tbl[1] = '{16'h4567, {7'h19, 7'h12, 7'h02, 7'h78}};
    tbl[2] = '{16'h89AB, {7'h00, 7'h10, 7'h08, 7'h03}};
    tbl[3] = '{16'hCDEF, {7'h46, 7'h21, 7'h06, 7'h0E}};
    tbl[4] = '{16'hFFFF, {7'h0E, 7'h0E, 7'h0E, 7'h0E}};
    tbl[5] = '{16'h1234, SEG_1234};

    // Reset and release
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("reset_seg", seg, SEG_BLANK28);
    check("reset_page", page, 0);
    check("reset_frozen", frozen, 0);
    repeat (2) tick_cycle();
    rst = 1'b0;
    tick_cycle();
    check("release_edge1_seg", seg, SEG_0000);
    tick_cycle();
    check("release_edge2_seg", seg, SEG_1234);
    check("release_page", page, 0);
    check("release_frozen", frozen, 0);

    // Encoding table through word 0
    for (int i = 0; i < 6; i++) begin
      words[15:0] = tbl[i].w;
      repeat (2) tick_cycle();
      check("hex_table", seg, tbl[i].s);
    end
    words = WORDS_DEF;
    repeat (2) tick_cycle();

    // Short glitch is rejected
    nxt = 1'b1;
    repeat (3) tick_cycle();
    nxt = 1'b0;
    repeat (8) tick_cycle();
    check("glitch_page", page, 0);

    // Held press: page moves exactly DEB+3 edges after the rise
    nxt = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick_cycle();
      if (e == 6) check("next_edge6", page, 0);
      if (e == 7) check("next_edge7", page, 1);
    end
    nxt = 1'b0;
    repeat (10) tick_cycle();
    check("next_release_page", page, 1);
    check("next_seg", seg, SEG_ABCD);

    // Prev wrap, next wrap, simultaneous press
    press_btn(1'b0, 1'b1);
    check("prev_1_to_0", page, 0);
    press_btn(1'b0, 1'b1);
    check("prev_wrap", page, 2);
    check("prev_wrap_seg", seg, SEG_0F00);
    press_btn(1'b1, 1'b0);
    check("next_wrap", page, 0);
    check("next_wrap_seg", seg, SEG_1234);
    press_btn(1'b1, 1'b1);
    check("both_page", page, 0);

    // Auto-scroll cadence
    aut = 1'b1;
    for (int e = 1; e <= 32; e++) begin
      tick_cycle();
      if (e == 11) check("auto_e11", page, 0);
      if (e == 12) check("auto_e12", page, 1);
      if (e == 21) check("auto_e21", page, 1);
      if (e == 22) check("auto_e22", page, 2);
      if (e == 32) check("auto_e32", page, 0);
    end
    // Manual press lands on the terminal count
    repeat (3) tick_cycle();
    nxt = 1'b1;
    for (int e = 1; e <= 17; e++) begin
      tick_cycle();
      if (e == 8) nxt = 1'b0;
      if (e == 6)  check("coinc_e6", page, 0);
      if (e == 7)  check("coinc_e7", page, 1);
      if (e == 16) check("coinc_e16", page, 1);
      if (e == 17) check("coinc_e17", page, 2);
    end
    aut = 1'b0;
    repeat (4) tick_cycle();
    press_btn(1'b1, 1'b0);
    check("pre_freeze_page", page, 0);

    // Freeze snapshot
    frz = 1'b1;
    repeat (2) tick_cycle();
    check("freeze_e2", frozen, 0);
    tick_cycle();
    check("freeze_e3", frozen, 1);
    words = '0;
    repeat (4) tick_cycle();
    check("frozen_seg", seg, SEG_1234);
    press_btn(1'b1, 1'b0);
    check("frozen_page_seg", seg, SEG_ABCD);
    frz = 1'b0;
    repeat (5) tick_cycle();
    check("unfreeze_frozen", frozen, 0);
    check("unfreeze_seg", seg, SEG_0000);

    // Reset mid-debounce, mid-scroll, while frozen
    words = WORDS_DEF;
    frz = 1'b1;
    aut = 1'b1;
    repeat (5) tick_cycle();
    nxt = 1'b1;
    repeat (4) tick_cycle();
    rst = 1'b1;
    model_reset();
    #1;
    check("midrst_seg", seg, SEG_BLANK28);
    check("midrst_page", page, 0);
    check("midrst_frozen", frozen, 0);
    repeat (2) tick_cycle();
    aut = 1'b0;
    frz = 1'b0;
    rst = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      tick_cycle();
      if (e == 6) check("postrst_e6", page, 0);
      if (e == 7) check("postrst_e7", page, 1);
    end
    nxt = 1'b0;
    repeat (10) tick_cycle();

    // Randomized run against the model
    for (int i = 0; i < 4; i++) cd[i] = 0;
    rst_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      tick_cycle();
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst = 1'b0;
      end else if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        model_reset();
        rst_hold = $urandom_range(1, 2);
        #1;
        cmp_outputs("async_reset");
      end
      for (int i = 0; i < 4; i++) begin
        if (cd[i] == 0) begin
          v = 1'($urandom_range(0, 1));
          cd[i] = (i < 2) ? $urandom_range(1, 10) : $urandom_range(5, 80);
          case (i)
            0:       nxt = v;
            1:       prv = v;
            2:       frz = v;
            default: aut = v;
          endcase
        end else begin
          cd[i]--;
        end
      end
      if ($urandom_range(0, 24) == 0) words = {16'($urandom), 16'($urandom), 16'($urandom)};
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dbg_pager.md
# dbg_pager

Parametrised debug-word pager for development builds. It takes NUM_WORDS packed debug words from the DUT and shows one word at a time on a bank of active-low 7-segment digits. Debounced next/prev buttons select the word, an optional auto-scroll mode steps through the words, and a freeze mode holds a coherent snapshot. It sits in the development chassis between the DUT test outputs and the HEX pins, and removes the fixed two-word limit.

## Interface
- NUM_WORDS, 4: number of debug words; ≥1.
- WORD_W, 16: bits per word; a multiple of 4. DIGITS = WORD_W/4 (derived).
- DEBOUNCE_CYC, 65536: consecutive stable cycles required to accept a button level change; ≥1.
- SCROLL_CYC, 8333333: cycles per auto-scroll step; ≥1.

Ports:
- pgr_clk_i  in  1  clock; all state on rising edge.
- pgr_rst_i  in  1  reset, asynchronous, active-high.
- pgr_words_i  in  NUM_WORDS*WORD_W  live words; word k is [k*WORD_W +: WORD_W].
- pgr_next_i  in  1  raw button, active-high, asynchronous to clock.
- pgr_prev_i  in  1  raw button, active-high, asynchronous to clock.
- pgr_freeze_i  in  1  level switch, asynchronous; high = freeze.
- pgr_auto_i  in  1  level switch, asynchronous; high = auto-scroll.
- pgr_seg_o  out  7*DIGITS  segment controls, active-low, gfedcba order; digit d (nibble d) is [7d +: 7].
- pgr_page_o  out  PAGE_W  current word index; PAGE_W = max(1, clog2(NUM_WORDS)).
- pgr_frozen_o  out  1  snapshot active.

## Operation
- All four asynchronous inputs pass through 2-flop synchronisers.
- **Debounce (next/prev):**
  - The stable level flips only after the synchronised input has differed from it for DEBOUNCE_CYC consecutive cycles.
  - The counter clears whenever the two agree.
  - A press is a 0→1 flip of the stable level. Releases generate nothing.
- **Page register:**
  - Next: page+1, wrapping NUM_WORDS-1→0.
  - Prev: page-1, wrapping 0→NUM_WORDS-1.
  - Next and prev in the same cycle: no change.
  - NUM_WORDS=1: page stays 0.
- **Auto-scroll:**
  - While synced auto=1, the scroll counter counts 0..SCROLL_CYC-1. On the terminal count it wraps to 0 and advances the page as a next press.
  - While auto=0, the counter is held at 0.
  - Any manual press clears the counter.
  - A manual press and the terminal count in the same cycle: the manual action wins and the tick is discarded.
- **Freeze:**
  - On the edge where synced freeze=1 and frozen=0, all NUM_WORDS words are captured into the snapshot and frozen is set.
  - While frozen, the display source is the snapshot. Paging and scrolling still work over the snapshot.
  - Synced freeze=0 clears frozen and returns the display to the live words. Snapshot contents are retained but unused.
- **Display:**
  - disp register <= source[page].
  - pgr_seg_o register <= hex encoding of each nibble of disp.
  - Encoding examples: 0→7'b1000000, 1→7'b1111001, A→7'b0001000, F→7'b0001110.
- **Reset (asynchronous, any time, including mid-debounce or mid-scroll):**
  - page=0, pgr_seg_o = all 1s (blank), frozen=0.
  - Synchronisers, stable levels, debounce and scroll counters, disp and snapshot all cleared to 0.

## Timing
- Live word change to pgr_seg_o: 2 cycles (disp, then seg).
- Raw button rise, held stable, to pgr_page_o change: DEBOUNCE_CYC+3 edges (2 sync, DEBOUNCE_CYC debounce, 1 page). pgr_seg_o follows 2 cycles later.
- Raw freeze rise to pgr_frozen_o=1 and snapshot capture: 3 edges. The snapshot holds the words present at that edge.
- Auto-scroll step period: exactly SCROLL_CYC cycles.
- After reset release, pgr_seg_o shows word 0 on the 2nd edge.
- Counters are sized from parameters (clog2) with no overflow. Page arithmetic is modulo NUM_WORDS, not 2^PAGE_W.

## Structure
- Package dbg_pager_pkg holds:
  - SEG_BLANK (7'h7F).
  - The hex-to-segment function (16-entry constant).
  - A page-width function max(1, clog2(n)).
- Sub-module pgr_debounce (synchroniser, counter, stable level, press pulse), parameter DEBOUNCE_CYC, instantiated for next and prev.
- The top level holds the page FSM, scroll counter, snapshot, and display pipeline.

## Test plan
Bench parameters: NUM_WORDS=3, WORD_W=16, DEBOUNCE_CYC=4, SCROLL_CYC=10. Words = {0x1234, 0xABCD, 0x0F00}.

- Reset then release: pgr_seg_o=all 1s during reset. Second edge after release shows 1234; page=0; frozen=0.
- 3-cycle next glitch: no page change. Next held 8 cycles: page 0→1 exactly 7 edges after the rise; seg shows ABCD; release gives no further change.
- Prev from page 0 → page 2 (0F00). Next from 2 → 0. Next and prev asserted together and held → page unchanged.
- Auto=1: page sequence 0,1,2,0 at 10-cycle intervals. A manual press landing on a terminal count advances once, and the next auto step comes 10 cycles after the press.
- Freeze=1, then words changed to {0,0,0}: display stays 1234, and paging shows ABCD. Freeze=0: display shows 0000 within 2+2 cycles.
- Reset asserted mid-debounce (counter=2) and mid-scroll: all outputs return to reset values immediately. A subsequent full press still needs the full DEBOUNCE_CYC.
